sdi_tx_line_sequencer: RTL and testbench

//  Builds the raster word stream for custom_sdi_tx. Per line it emits EAV TRS, horizontal

---
 rtl/sdi_pkg.sv | 35 +++
 rtl/sdi_trs_xyz_gen.sv | 14 +
 rtl/sdi_tx_line_sequencer.sv | 128 ++++++++++++
 tb/tb_sdi_tx_line_sequencer.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdi_pkg.sv
// Shared constants, state encoding and word helpers for the SDI raster sequencer.
package sdi_pkg;

  // Element [0] is sent first.
  localparam logic [2:0][9:0] TRS_PREAMBLE = {10'h000, 10'h000, 10'h3FF};
  localparam logic [9:0] FILL_CB = 10'h200;
  localparam logic [9:0] FILL_Y  = 10'h040;
  localparam logic [9:0] CLIP_LO = 10'h004;
  localparam logic [9:0] CLIP_HI = 10'h3FB;
  localparam int         TRS_WORDS = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EAV,
    ST_HBLANK,
    ST_SAV,
    ST_ACTIVE
  } state_t;

  function automatic logic [9:0] xyz(input logic f, input logic v, input logic h);
    return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h, 2'b00};
  endfunction

  function automatic logic [9:0] fill_word(input logic odd);
    return odd ? FILL_Y : FILL_CB;
  endfunction

  // Keeps video out of the 000-003 / 3FC-3FF ranges reserved for TRS.
  function automatic logic [9:0] clip(input logic [9:0] d);
    if (d < CLIP_LO) return CLIP_LO;
    if (d > CLIP_HI) return CLIP_HI;
    return d;
  endfunction

endpackage

// File: rtl/sdi_trs_xyz_gen.sv
// Combinational TRS status word (XYZ) with protection bits from F/V/H.
// Zero latency; no flow control.
module sdi_trs_xyz_gen
  import sdi_pkg::*;
(
  input  logic       f,
  input  logic       v,
  input  logic       h,
  output logic [9:0] xyz_word
);

  assign xyz_word = xyz(f, v, h);

endmodule

// File: rtl/sdi_tx_line_sequencer.sv
// Raster sequencer EAV/HBLANK/SAV/ACTIVE feeding custom_sdi_tx; one word per clk, 1-cycle latency.
// Backpressure: ready outputs decode only state and V; missing video is replaced by fill.
module sdi_tx_line_sequencer
  import sdi_pkg::*;
#(
  parameter int ACTIVE_WORDS = 1440,
  parameter int BLANK_WORDS  = 268,
  parameter int LINES        = 525,
  parameter int VBLANK_LINES = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [9:0]  vid_data,
  input  logic        vid_valid,
  output logic        vid_ready,
  input  logic [9:0]  anc_data,
  input  logic        anc_valid,
  output logic        anc_ready,
  output logic [9:0]  tx_datain,
  output logic        tx_datain_valid,
  output logic [10:0] line_count,
  output logic        frame_start,
  output logic        underflow,
  input  logic        clear_underflow
);

  localparam int MAXW_AB = (ACTIVE_WORDS > BLANK_WORDS) ? ACTIVE_WORDS : BLANK_WORDS;
  localparam int MAXW    = (MAXW_AB > TRS_WORDS) ? MAXW_AB : TRS_WORDS;
  localparam int CW      = $clog2(MAXW);

  localparam logic [CW-1:0] LAST_ACT   = CW'(ACTIVE_WORDS - 1);
  localparam logic [CW-1:0] LAST_BLANK = CW'(BLANK_WORDS - 1);
  localparam logic [CW-1:0] LAST_TRS   = CW'(TRS_WORDS - 1);
  localparam logic [10:0]   LAST_LINE  = 11'(LINES - 1);
  localparam logic [10:0]   VBL        = 11'(VBLANK_LINES);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          restart;
  logic          v_blank;
  logic [9:0]    xyz_w;
  logic [10:0]   next_line;

  assign v_blank   = (line_count < VBL);
  assign vid_ready = (state == ST_ACTIVE) && !v_blank;
  assign anc_ready = (state == ST_HBLANK);
  assign next_line = (restart || line_count == LAST_LINE) ? 11'd0 : line_count + 11'd1;

  sdi_trs_xyz_gen u_xyz (
    .f        (1'b0),
    .v        (v_blank),
    .h        (state == ST_EAV),
    .xyz_word (xyz_w)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      restart         <= 1'b0;
      tx_datain       <= '0;
      tx_datain_valid <= 1'b0;
      line_count      <= '0;
      frame_start     <= 1'b0;
      underflow       <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (clear_underflow)
        underflow <= 1'b0;
      else if (state == ST_ACTIVE && !v_blank && !vid_valid)
        underflow <= 1'b1;

      case (state)
        ST_IDLE: begin
          tx_datain       <= '0;
          tx_datain_valid <= 1'b0;
          cnt             <= '0;
          if (enable) begin
            state   <= ST_EAV;
            restart <= 1'b1;
          end
        end
        ST_EAV, ST_SAV: begin
          tx_datain_valid <= 1'b1;
          tx_datain       <= (cnt[1:0] == 2'd3) ? xyz_w : TRS_PREAMBLE[cnt[1:0]];
          // Line advances with the first EAV word so V/H of this EAV reflect the new line.
          if (state == ST_EAV && cnt == '0) begin
            line_count  <= next_line;
            frame_start <= (next_line == 11'd0);
            restart     <= 1'b0;
          end
          if (cnt == LAST_TRS) begin
            state <= (state == ST_EAV) ? ST_HBLANK : ST_ACTIVE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_HBLANK: begin
          tx_datain_valid <= 1'b1;
          tx_datain       <= anc_valid ? anc_data : fill_word(cnt[0]);
          if (cnt == LAST_BLANK) begin
            state <= ST_SAV;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_ACTIVE: begin
          tx_datain_valid <= 1'b1;
          tx_datain       <= (!v_blank && vid_valid) ? clip(vid_data) : fill_word(cnt[0]);
          if (cnt == LAST_ACT) begin
            state <= enable ? ST_EAV : ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdi_tx_line_sequencer.sv
// Bench for sdi_tx_line_sequencer: randomized stimulus against a raster-position reference model.
module tb_sdi_tx_line_sequencer;

  localparam int AW  = 8;
  localparam int BW  = 4;
  localparam int NL  = 4;
  localparam int VBL = 1;
  localparam int LW  = 4 + BW + 4 + AW;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [9:0]  vid_data;
  logic        vid_valid;
  logic        vid_ready;
  logic [9:0]  anc_data;
  logic        anc_valid;
  logic        anc_ready;
  logic [9:0]  tx_datain;
  logic        tx_datain_valid;
  logic [10:0] line_count;
  logic        frame_start;
  logic        underflow;
  logic        clear_underflow;

  always #5 clk = ~clk;

  sdi_tx_line_sequencer #(
    .ACTIVE_WORDS (AW),
    .BLANK_WORDS  (BW),
    .LINES        (NL),
    .VBLANK_LINES (VBL)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .enable          (enable),
    .vid_data        (vid_data),
    .vid_valid       (vid_valid),
    .vid_ready       (vid_ready),
    .anc_data        (anc_data),
    .anc_valid       (anc_valid),
    .anc_ready       (anc_ready),
    .tx_datain       (tx_datain),
    .tx_datain_valid (tx_datain_valid),
    .line_count      (line_count),
    .frame_start     (frame_start),
    .underflow       (underflow),
    .clear_underflow (clear_underflow)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: position p counts words since the raster was started from idle.
  bit          running;
  int          p;
  logic [10:0] m_lc;
  logic        m_uf;
  int          vr_seen;
  int          fs_seen;

  function automatic logic [9:0] ref_xyz(input bit v, input bit h);
    case ({v, h})
      2'b00:   return 10'h200;
      2'b01:   return 10'h274;
      2'b10:   return 10'h2AC;
      default: return 10'h2D8;
    endcase
  endfunction

  function automatic logic [9:0] ref_fill(input int k);
    return (k % 2 == 0) ? 10'h200 : 10'h040;
  endfunction

  function automatic logic [9:0] ref_clip(input logic [9:0] d);
    if (d < 10'd4) return 10'd4;
    if (d > 10'h3FB) return 10'h3FB;
    return d;
  endfunction

  function automatic int cur_w();
    return p % LW;
  endfunction

  function automatic int cur_ln();
    return (p / LW) % NL;
  endfunction

  task automatic model_reset();
    running = 0;
    p       = 0;
    m_lc    = '0;
    m_uf    = 1'b0;
  endtask

  // One clock: inputs are already driven; check readies, clock, check registered outputs.
  task automatic step();
    int         w;
    int         ln;
    bit         v;
    bit         uf_set;
    bit         exp_vr;
    bit         exp_ar;
    bit         exp_fs;
    logic [9:0] ed;
    logic       ev;
    w      = cur_w();
    ln     = cur_ln();
    v      = (ln < VBL);
    ed     = '0;
    ev     = 1'b0;
    exp_fs = 1'b0;
    uf_set = 1'b0;
    exp_vr = running && w >= 12 && !v;
    exp_ar = running && w >= 4 && w < 8;

    checks++;
    if (vid_ready !== exp_vr) begin
      failures++;
      $display("FAIL vid_ready p=%0d got=%b exp=%b", p, vid_ready, exp_vr);
    end
    checks++;
    if (anc_ready !== exp_ar) begin
      failures++;
      $display("FAIL anc_ready p=%0d got=%b exp=%b", p, anc_ready, exp_ar);
    end
    if (vid_ready === 1'b1) vr_seen++;

    if (running) begin
      ev = 1'b1;
      if (w < 4 || (w >= 8 && w < 12)) begin
        int k;
        k  = (w < 4) ? w : w - 8;
        ed = (k == 0) ? 10'h3FF : (k == 3) ? ref_xyz(v, w < 4) : 10'h000;
        if (w == 0) begin
          m_lc   = 11'(ln);
          exp_fs = (ln == 0);
        end
      end else if (w < 8) begin
        ed = anc_valid ? anc_data : ref_fill(w - 4);
      end else begin
        ed = (!v && vid_valid) ? ref_clip(vid_data) : ref_fill(w - 12);
        uf_set = !v && !vid_valid;
      end
    end
    m_uf = clear_underflow ? 1'b0 : (m_uf | uf_set);

    @(posedge clk);
    #1;
    checks++;
    if (tx_datain !== ed) begin
      failures++;
      $display("FAIL tx_datain p=%0d got=%h exp=%h", p, tx_datain, ed);
    end
    checks++;
    if (tx_datain_valid !== ev) begin
      failures++;
      $display("FAIL tx_valid p=%0d got=%b exp=%b", p, tx_datain_valid, ev);
    end
    checks++;
    if (frame_start !== exp_fs) begin
      failures++;
      $display("FAIL frame_start p=%0d got=%b exp=%b", p, frame_start, exp_fs);
    end
    checks++;
    if (line_count !== m_lc) begin
      failures++;
      $display("FAIL line_count p=%0d got=%0d exp=%0d", p, line_count, m_lc);
    end
    checks++;
    if (underflow !== m_uf) begin
      failures++;
      $display("FAIL underflow p=%0d got=%b exp=%b", p, underflow, m_uf);
    end
    if (frame_start === 1'b1) fs_seen++;

    if (!running) begin
      if (enable) begin
        running = 1;
        p       = 0;
      end
    end else begin
      if (w == LW - 1 && !enable) running = 0;
      p++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; vid_valid = 1'b0; anc_valid = 1'b0;
    vid_data = '0; anc_data = '0; clear_underflow = 1'b0;
    model_reset();
    #3;
    checks++;
    if ({tx_datain, tx_datain_valid, vid_ready, anc_ready, line_count, frame_start, underflow} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got tx=%h v=%b vr=%b ar=%b lc=%0d fs=%b uf=%b exp=all zero",
               tx_datain, tx_datain_valid, vid_ready, anc_ready, line_count, frame_start, underflow);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step();
    step();
  endtask

  task automatic test_line0_fill();
    fs_seen = 0;
    enable  = 1'b1;
    for (int i = 0; i < LW + 1; i++) begin
      vid_data = 10'($urandom_range(0, 1023));
      anc_data = 10'($urandom_range(0, 1023));
      step();
    end
    checks++;
    if (fs_seen != 1) begin
      failures++;
      $display("FAIL frame_start_count got=%0d exp=1", fs_seen);
    end
  endtask

  task automatic test_video_clip();
    logic [9:0] fixed [3];
    fixed[0] = 10'h001; fixed[1] = 10'h3FF; fixed[2] = 10'h155;
    vr_seen   = 0;
    vid_valid = 1'b1;
    for (int i = 0; i < LW; i++) begin
      if (cur_w() >= 12 && cur_w() < 15) vid_data = fixed[cur_w() - 12];
      else vid_data = 10'($urandom_range(0, 1023));
      step();
    end
    checks++;
    if (vr_seen != AW) begin
      failures++;
      $display("FAIL vid_ready_cycles got=%0d exp=%0d", vr_seen, AW);
    end
  endtask

  task automatic test_underflow();
    int drop;
    drop = $urandom_range(0, AW - 1);
    for (int i = 0; i < LW; i++) begin
      vid_valid = (cur_w() != 12 + drop);
      vid_data  = 10'($urandom_range(0, 1023));
      step();
    end
    vid_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      clear_underflow = (i == 1);
      step();
    end
    clear_underflow = 1'b0;
  endtask

  task automatic test_anc();
    for (int i = 0; i < 16 + LW; i++) begin
      int w;
      int ln;
      w  = cur_w();
      ln = cur_ln();
      vid_data = 10'($urandom_range(0, 1023));
      if (ln == 3 && (w == 4 || w == 5)) begin
        anc_valid = 1'b1;
        anc_data  = (w == 4) ? 10'h0A1 : 10'h0A2;
      end else if ((ln == 3 && w >= 8) || (ln == 0 && w <= 4)) begin
        anc_valid = 1'b1;
        anc_data  = 10'h1C3;
      end else begin
        anc_valid = 1'b0;
        anc_data  = 10'($urandom_range(0, 1023));
      end
      step();
    end
    anc_valid = 1'b0;
  endtask

  task automatic test_enable_drop();
    bit dropped;
    int idle_cnt;
    dropped  = 0;
    idle_cnt = 0;
    for (int i = 0; i < 100 && idle_cnt < 3; i++) begin
      if (running && cur_ln() == 2 && cur_w() == 15) dropped = 1;
      enable    = !dropped;
      vid_valid = ($urandom_range(0, 9) != 0);
      vid_data  = 10'($urandom_range(0, 1023));
      step();
      if (dropped && !running) idle_cnt++;
    end
    checks++;
    if (idle_cnt < 3) begin
      failures++;
      $display("FAIL enable_drop_idle got=%0d idle cycles exp=3", idle_cnt);
    end
    fs_seen = 0;
    enable  = 1'b1;
    for (int i = 0; i < LW + 1; i++) step();
    checks++;
    if (fs_seen != 1) begin
      failures++;
      $display("FAIL restart_frame_start got=%0d exp=1", fs_seen);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      enable          = ($urandom_range(0, 9) != 0);
      vid_valid       = ($urandom_range(0, 99) < 85);
      anc_valid       = $urandom_range(0, 1) == 1;
      clear_underflow = ($urandom_range(0, 19) == 0);
      vid_data        = 10'($urandom_range(0, 1023));
      anc_data        = 10'($urandom_range(0, 1023));
      step();
    end
    clear_underflow = 1'b0;
    anc_valid       = 1'b0;
  endtask

  task automatic test_async_reset();
    bit found;
    found  = 0;
    enable = 1'b1;
    for (int i = 0; i < 100 && !found; i++) begin
      vid_valid = 1'b1;
      vid_data  = 10'($urandom_range(0, 1023));
      step();
      found = running && (cur_w() == 9);
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL reach_sav got=not reached exp=SAV word 1");
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({tx_datain, tx_datain_valid, vid_ready, anc_ready, line_count, frame_start, underflow} !== '0) begin
      failures++;
      $display("FAIL async_reset got tx=%h v=%b vr=%b ar=%b lc=%0d fs=%b uf=%b exp=all zero",
               tx_datain, tx_datain_valid, vid_ready, anc_ready, line_count, frame_start, underflow);
    end
    model_reset();
    #2;
    reset_n = 1'b1;
    enable  = 1'b0;
    for (int i = 0; i < 3; i++) step();
    fs_seen = 0;
    enable  = 1'b1;
    for (int i = 0; i < LW + 1; i++) step();
    checks++;
    if (fs_seen != 1) begin
      failures++;
      $display("FAIL post_reset_frame_start got=%0d exp=1", fs_seen);
    end
  endtask

  initial begin
    test_reset();
    test_line0_fill();
    test_video_clip();
    test_underflow();
    test_anc();
    test_enable_drop();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=bench completion");
    $fatal(1);
  end

endmodule
